// File: rtl/ps2_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx_if
//  Description : Bundle of PS/2 line inputs, receive enable and the
//                scan-code result outputs of the PS/2 frame receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_frame_rx_if;
  logic       rx_en;
  logic       ps2d;
  logic       ps2c;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       busy;

  // Drives the PS/2 lines and enable, observes results (bench / upstream).
  modport master (
    output rx_en, ps2d, ps2c,
    input  rx_done_tick, dout, frame_err, busy
  );

  // The receiver itself.
  modport slave (
    input  rx_en, ps2d, ps2c,
    output rx_done_tick, dout, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : PS/2 device-to-host frame receiver. Synchronises and
//                glitch-filters the PS/2 clock, shifts in 11-bit frames,
//                checks odd parity and stop bit, and abandons truncated
//                frames through an inter-edge watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_frame_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  ps2_frame_rx_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] c_hist;
  logic                  c_filt;
  logic                  c_filt_d;
  logic                  fall_tick;
  logic                  d_bit;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [WD_W-1:0]       wd, wd_n;
  logic [9:0]            sh, sh_n;
  logic [7:0]            dout_r, dout_n;
  logic                  done_r, done_n;
  logic                  err_r, err_n;

  // Two-flop synchronisers for both asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], bus.ps2c};
      d_sync <= {d_sync[0], bus.ps2d};
    end
  end

  // Clock filter: level only changes after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_hist   <= '1;
      c_filt   <= 1'b1;
      c_filt_d <= 1'b1;
    end else begin
      c_hist <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
      if (c_hist == '0)
        c_filt <= 1'b0;
      else if (c_hist == '1)
        c_filt <= 1'b1;
      c_filt_d <= c_filt;
    end
  end

  assign fall_tick = c_filt_d & ~c_filt;
  assign d_bit     = d_sync[1];

  // FSM and datapath state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wd     <= '0;
      sh     <= 10'd0;
      dout_r <= 8'h00;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wd     <= wd_n;
      sh     <= sh_n;
      dout_r <= dout_n;
      done_r <= done_n;
      err_r  <= err_n;
    end
  end

  // Next-state logic: start detection, bit shifting, watchdog, frame check.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wd_n    = wd;
    sh_n    = sh;
    dout_n  = dout_r;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (fall_tick && bus.rx_en && !d_bit) begin
          cnt_n   = 4'd0;
          wd_n    = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          sh_n  = {d_bit, sh[9:1]};
          cnt_n = cnt + 4'd1;
          wd_n  = '0;
          // Counter holds the number of bits already taken; 9 means this
          // edge delivers the stop bit.
          if (cnt == 4'd9)
            state_n = CHECK;
        end else if (wd == WD_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wd_n = wd + WD_ONE;
        end
      end
      CHECK: begin
        // sh[9] = stop, sh[8] = parity, sh[7:0] = data.
        if (sh[9] && (^sh[8:0])) begin
          dout_n = sh[7:0];
          done_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.rx_done_tick = done_r;
  assign bus.frame_err    = err_r;
  assign bus.dout         = dout_r;
  assign bus.busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_frame_rx
//  Description : Self-checking bench for ps2_frame_rx: directed scenarios
//                plus random frames compared against a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_frame_rx;

  logic clk;
  logic reset;
  ps2_frame_rx_if bus ();

  ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT(2000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;
  int n_busy   = 0;
  int last_done_cyc = 0;
  int last_err_cyc  = 0;
  int last_fall_cyc = 0;
  logic [7:0] exp_dout;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      n_done <= n_done + 1;
      last_done_cyc <= cyc;
    end
    if (bus.frame_err) begin
      n_err <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (bus.rx_done_tick && bus.frame_err) n_both <= n_both + 1;
    if (bus.busy) n_busy <= n_busy + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive nbits of a frame, bit 0 first; 400-cycle period, data changed mid-high.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2c = 1'b1;
      wait_cyc(100);
      bus.ps2d = bits[i];
      wait_cyc(100);
      bus.ps2c = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(200);
    end
    bus.ps2c = 1'b1;
    wait_cyc(100);
    bus.ps2d = 1'b1;
  endtask

  // Build a frame and predict its outcome from the framing rules alone.
  task automatic run_frame(input string tag, input logic [7:0] data,
                           input bit flip, input bit stop_bad, input bit en);
    logic [10:0] bits;
    logic par, stp;
    bit   valid;
    int   d0, e0, lat;
    par   = (($countones(data) % 2) == 0) ? 1'b1 : 1'b0;
    par   = par ^ flip;
    stp   = ~stop_bad;
    bits  = {stp, par, data, 1'b0};
    valid = en && stp && (($countones({par, data}) % 2) == 1);
    d0 = n_done;
    e0 = n_err;
    bus.rx_en = en;
    send_bits(bits, 11);
    wait_cyc(30);
    check_eq({tag, "_done"}, n_done - d0, valid ? 1 : 0);
    check_eq({tag, "_err"}, n_err - e0, (en && !valid) ? 1 : 0);
    if (valid) exp_dout = data;
    check_eq({tag, "_dout"}, {24'd0, bus.dout}, {24'd0, exp_dout});
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 0);
    if (valid) begin
      lat = last_done_cyc - last_fall_cyc;
      check_eq({tag, "_lat"}, (lat >= 10 && lat <= 16) ? 1 : 0, 1);
    end
  endtask

  // Absolute guard so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0, e0, b0, dly, k;
    logic [7:0] rd;
    reset    = 1'b0;
    bus.rx_en = 1'b0;
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    exp_dout = 8'h00;
    wait_cyc(5);
    check_eq("rst_busy", {31'd0, bus.busy}, 0);
    check_eq("rst_dout", {24'd0, bus.dout}, 0);
    check_eq("rst_done", {31'd0, bus.rx_done_tick}, 0);
    check_eq("rst_err",  {31'd0, bus.frame_err}, 0);
    reset = 1'b1;
    wait_cyc(20);

    // Single frame and back-to-back frames
    run_frame("f1c", 8'h1C, 0, 0, 1);
    run_frame("ff0", 8'hF0, 0, 0, 1);
    run_frame("f1c_b", 8'h1C, 0, 0, 1);

    // Good frame then bad parity keeps the old byte
    run_frame("f5a", 8'h5A, 0, 0, 1);
    run_frame("par", 8'h1C, 1, 0, 1);

    // Clock glitch while idle with data low
    d0 = n_done; e0 = n_err; b0 = n_busy;
    bus.ps2d = 1'b0;
    bus.ps2c = 1'b0;
    wait_cyc(5);
    bus.ps2c = 1'b1;
    wait_cyc(40);
    bus.ps2d = 1'b1;
    wait_cyc(20);
    check_eq("glitch_busy", n_busy - b0, 0);
    check_eq("glitch_done", n_done - d0, 0);
    check_eq("glitch_err",  n_err - e0, 0);
    run_frame("f29", 8'h29, 0, 0, 1);

    // Truncated frame: start plus 4 data bits, then the clock stays high
    d0 = n_done; e0 = n_err;
    send_bits({6'b0, 5'b10110}, 5);
    k = 0;
    while (n_err == e0 && k < 3000) begin
      wait_cyc(1);
      k++;
    end
    dly = last_err_cyc - last_fall_cyc;
    check_eq("to_err", n_err - e0, 1);
    check_eq("to_delay_ok", (dly >= 2000 && dly <= 2040) ? 1 : 0, 1);
    wait_cyc(5);
    check_eq("to_busy", {31'd0, bus.busy}, 0);
    check_eq("to_done", n_done - d0, 0);
    run_frame("f5a_b", 8'h5A, 0, 0, 1);

    // Reset in the middle of a frame
    d0 = n_done; e0 = n_err;
    send_bits({5'b0, 6'b001100}, 6);
    check_eq("mid_busy_before", {31'd0, bus.busy}, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_busy_rst", {31'd0, bus.busy}, 0);
    check_eq("mid_dout_rst", {24'd0, bus.dout}, 0);
    exp_dout = 8'h00;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(20);
    check_eq("mid_done", n_done - d0, 0);
    check_eq("mid_err",  n_err - e0, 0);
    run_frame("dis", 8'hF0, 0, 0, 0);
    run_frame("f1c_c", 8'h1C, 0, 0, 1);

    // Random frames against the frame-level model
    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", i), rd,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) != 0));
    end

    check_eq("excl_pulses", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
